fb_writer: RTL

Frame-buffer write stage that sits directly downstream of the camera output buffer FIFO. It pops 12-bit RGB444 pixels from the FIFO read port, aligns them to frame boundaries using a start-of-frame pulse, and issues linear-address writes into a single-port framebuffer RAM. It runs entirely in the FIFO read-clock domain and reports frame completion and framing errors.

---
 rtl/fb_pkg.sv | 31 +++
 rtl/rgb444_to_gray.sv | 34 +++
 rtl/fb_writer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// fb_pkg
// Shared definitions for the framebuffer write path: default raster size,
// framebuffer address width, writer FSM state encoding and the RGB444
// field positions inside a 12-bit pixel word.
// No ports (package).

package fb_pkg;

    // Default raster geometry and framebuffer address width.
    // 2**FB_ADDR_WIDTH must cover FB_H_ACTIVE*FB_V_ACTIVE.
    localparam int FB_H_ACTIVE   = 640;
    localparam int FB_V_ACTIVE   = 480;
    localparam int FB_ADDR_WIDTH = 19;

    // Pixel word layout: {R[3:0], G[3:0], B[3:0]}
    localparam int PIX_W = 12;
    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

    // Writer FSM states
    typedef enum logic [1:0] {
        FBW_IDLE   = 2'd0,
        FBW_ACTIVE = 2'd1,
        FBW_DRAIN  = 2'd2
    } fbw_state_t;

endpackage

// File: rtl/rgb444_to_gray.sv
// rgb444_to_gray
// Combinational luma approximation for RGB444 pixels.
// Y = (5*R + 9*G + 2*B) >> 4, replicated into all three channels.
// The weighted sum peaks at 240, so an 8-bit accumulator is exact and
// Y always fits in 4 bits.
// Ports:
//   rgb  in  12  pixel {R,G,B}
//   gray out 12  {Y,Y,Y}

module rgb444_to_gray
    import fb_pkg::*;
(
    input  logic [PIX_W-1:0] rgb,
    output logic [PIX_W-1:0] gray
);

    logic [7:0] r_ext;
    logic [7:0] g_ext;
    logic [7:0] b_ext;
    logic [7:0] luma_sum;
    logic [3:0] luma;

    // Widen each channel to 8 bits before weighting so the products and
    // their sum stay exact.
    always_comb begin
        r_ext    = {4'd0, rgb[R_MSB:R_LSB]};
        g_ext    = {4'd0, rgb[G_MSB:G_LSB]};
        b_ext    = {4'd0, rgb[B_MSB:B_LSB]};
        luma_sum = (r_ext * 8'd5) + (g_ext * 8'd9) + (b_ext * 8'd2);
        luma     = luma_sum[7:4];
        gray     = {luma, luma, luma};
    end

endmodule

// File: rtl/fb_writer.sv
// fb_writer
// Framebuffer write stage fed from the camera output FIFO. Pops RGB444
// pixels, aligns them to frames with a start-of-frame pulse and writes
// them to linear framebuffer addresses. Surplus pixels after a full frame
// are read and discarded so the FIFO never backs up.
//
// Optional feature: define FB_WRITER_GRAY_EN to write grayscale {Y,Y,Y}
// instead of the raw pixel (same latency).
//
// Ports:
//   i_clk          in   1   clock (also the FIFO read clock)
//   i_rstn         in   1   asynchronous active-low reset
//   i_enable       in   1   allows new FIFO reads while a frame is active
//   i_sof          in   1   single-cycle start-of-frame pulse
//   o_obuf_rd      out  1   FIFO read enable (combinational)
//   i_obuf_data    in   12  FIFO read data, valid the cycle after o_obuf_rd
//   i_obuf_empty   in   1   FIFO empty flag
//   o_fb_wr        out  1   framebuffer write strobe
//   o_fb_addr      out  ADDR_WIDTH framebuffer write address
//   o_fb_wdata     out  12  framebuffer write data
//   o_frame_done   out  1   pulse with the write of the last pixel of a frame
//   o_short_frame  out  1   pulse the cycle after i_sof arrives mid-frame
//   o_frame_cnt    out  8   completed-frame counter (wraps)

module fb_writer
    import fb_pkg::*;
#(
    parameter int H_ACTIVE   = FB_H_ACTIVE,
    parameter int V_ACTIVE   = FB_V_ACTIVE,
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_enable,
    input  logic                  i_sof,
    output logic                  o_obuf_rd,
    input  logic [PIX_W-1:0]      i_obuf_data,
    input  logic                  i_obuf_empty,
    output logic                  o_fb_wr,
    output logic [ADDR_WIDTH-1:0] o_fb_addr,
    output logic [PIX_W-1:0]      o_fb_wdata,
    output logic                  o_frame_done,
    output logic                  o_short_frame,
    output logic [7:0]            o_frame_cnt
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    fbw_state_t            state_q;
    fbw_state_t            state_d;
    logic [ADDR_WIDTH-1:0] pix_cnt_q;
    logic [ADDR_WIDTH-1:0] pix_cnt_d;
    logic                  rd_pend_q;
    logic                  fb_wr_d;
    logic [ADDR_WIDTH-1:0] fb_addr_d;
    logic [PIX_W-1:0]      fb_wdata_d;
    logic                  frame_done_d;
    logic                  short_frame_d;
    logic [7:0]            frame_cnt_d;
    logic [PIX_W-1:0]      pix_conv;

`ifdef FB_WRITER_GRAY_EN
    rgb444_to_gray u_gray (
        .rgb  (i_obuf_data),
        .gray (pix_conv)
    );
`else
    assign pix_conv = i_obuf_data;
`endif

    // Next-state and output decode. rd_pend_q marks that FIFO data is on
    // i_obuf_data this cycle; it is written only while ACTIVE and only if
    // no i_sof arrives in the same cycle (that word belongs to the frame
    // being abandoned). Reaching the last pixel moves to DRAIN, where
    // reads continue regardless of i_enable but nothing is written.
    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        fb_wr_d       = 1'b0;
        fb_addr_d     = o_fb_addr;
        fb_wdata_d    = o_fb_wdata;
        frame_done_d  = 1'b0;
        short_frame_d = 1'b0;
        frame_cnt_d   = o_frame_cnt;
        o_obuf_rd     = 1'b0;

        case (state_q)
            FBW_IDLE: begin
                if (i_sof) begin
                    state_d   = FBW_ACTIVE;
                    pix_cnt_d = '0;
                end
            end

            FBW_ACTIVE: begin
                o_obuf_rd = i_enable && !i_obuf_empty;
                if (i_sof) begin
                    short_frame_d = 1'b1;
                    pix_cnt_d     = '0;
                end else if (rd_pend_q) begin
                    fb_wr_d    = 1'b1;
                    fb_addr_d  = pix_cnt_q;
                    fb_wdata_d = pix_conv;
                    pix_cnt_d  = pix_cnt_q + ADDR_ONE;
                    if (pix_cnt_q == LAST_PIX) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = o_frame_cnt + 8'd1;
                        pix_cnt_d    = '0;
                        state_d      = FBW_DRAIN;
                    end
                end
            end

            FBW_DRAIN: begin
                o_obuf_rd = !i_obuf_empty;
                if (i_sof) begin
                    state_d   = FBW_ACTIVE;
                    pix_cnt_d = '0;
                end
            end

            default: begin
                state_d = FBW_IDLE;
            end
        endcase
    end

    // State, pixel counter, read-pending flag and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q       <= FBW_IDLE;
            pix_cnt_q     <= '0;
            rd_pend_q     <= 1'b0;
            o_fb_wr       <= 1'b0;
            o_fb_addr     <= '0;
            o_fb_wdata    <= '0;
            o_frame_done  <= 1'b0;
            o_short_frame <= 1'b0;
            o_frame_cnt   <= 8'd0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            rd_pend_q     <= o_obuf_rd;
            o_fb_wr       <= fb_wr_d;
            o_fb_addr     <= fb_addr_d;
            o_fb_wdata    <= fb_wdata_d;
            o_frame_done  <= frame_done_d;
            o_short_frame <= short_frame_d;
            o_frame_cnt   <= frame_cnt_d;
        end
    end

endmodule
